// File: rtl/rr_arb_pkg.sv
// Shared types, constants and width helpers for the round-robin arbiter family.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int unsigned REQ2GNT = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value m.
  function automatic int unsigned cnt_w(input int unsigned m);
    return idx_w(m + 1);
  endfunction

endpackage

// File: rtl/wrr_arb_ctrl_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr, modulo N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N   = 3,
  parameter int unsigned IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr < N and i < N, so one conditional subtract performs the modulo
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!valid && req[cand[IDW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_arb_ctrl.sv
// Weighted round-robin arbiter controller: 2-cycle request-to-grant, grant held until done,
// per-requester credits for back-to-back wins, and a hold watchdog.
module wrr_arb_ctrl
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned WT_W     = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          done,
  input  logic [N*WT_W-1:0]     weight,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   gnt_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned IDW = idx_w(N);
  localparam int unsigned HW  = cnt_w(MAX_HOLD);

  arb_state_e      state, state_n;
  logic [N-1:0]    gnt_n;
  logic [IDW-1:0]  gnt_id_n, ptr, ptr_n, pick_idx;
  logic            busy_n, terr_n, pick_valid;
  logic [WT_W-1:0] credit, credit_n, wsel;
  logic [HW-1:0]   hold_cnt, hold_n;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      credit      <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      gnt_id      <= gnt_id_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
      ptr         <= ptr_n;
      credit      <= credit_n;
      hold_cnt    <= hold_n;
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < N; i++)
      if (pick_idx == IDW'(i)) wsel = weight[i*WT_W +: WT_W];
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    busy_n   = busy;
    terr_n   = 1'b0;
    ptr_n    = ptr;
    credit_n = credit;
    hold_n   = hold_cnt;
    case (state)
      IDLE: if (|req) state_n = ARB;
      ARB: begin
        // gnt_id still names the last owner here, so it doubles as the re-win candidate
        if (req[gnt_id] && credit != '0) begin
          state_n         = GRANT;
          gnt_n           = '0;
          gnt_n[gnt_id]   = 1'b1;
          busy_n          = 1'b1;
          credit_n        = credit - 1'b1;
          hold_n          = '0;
        end else if (pick_valid) begin
          state_n         = GRANT;
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          gnt_id_n        = pick_idx;
          busy_n          = 1'b1;
          credit_n        = (wsel == '0) ? '0 : wsel - 1'b1;
          ptr_n           = (pick_idx == IDW'(N-1)) ? '0 : pick_idx + 1'b1;
          hold_n          = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (done[gnt_id]) begin
          state_n = ARB;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end else if (hold_cnt == HW'(MAX_HOLD-1)) begin
          state_n  = ARB;
          gnt_n    = '0;
          busy_n   = 1'b0;
          terr_n   = 1'b1;
          credit_n = '0;
        end else begin
          hold_n = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
